rf_write_arbiter: RTL

Shares the register file's single write port between the in-order pipeline writeback (port A) and the multi-cycle execution unit (port B: multiplier/divider). Port A always wins. Port B results are buffered in a small FIFO and drained on cycles when A does not write. The block reports pending buffered writes to the hazard unit and requests a pipeline stall when B is starved. It sits between the WB stage, the multi-cycle unit and the register file write inputs (wen/wsel/wdat).

---
 rtl/rf_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority, multi-cycle results (B) are queued.
// Optional same-cycle B bypass when the queue is empty: define RF_ARB_BYPASS_EN.
module rf_write_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        a_wen,
    input  logic [4:0]  a_wsel,
    input  logic [31:0] a_wdat,
    input  logic        b_valid,
    input  logic [4:0]  b_wsel,
    input  logic [31:0] b_wdat,
    output logic        b_ready,
    output logic        rf_wen,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    input  logic [4:0]  rsel1,
    input  logic [4:0]  rsel2,
    output logic        hit1,
    output logic        hit2,
    output logic        stall_req
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [4:0]    mem_wsel [DEPTH];
    logic [31:0]   mem_wdat [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] starve_cnt;

    logic a_eff;
    logic empty;
    logic full;
    logic byp;
    logic push;
    logic pop;

    assign a_eff   = a_wen & (a_wsel != '0);
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign b_ready = !full;

`ifdef RF_ARB_BYPASS_EN
    assign byp = empty & !a_eff & b_valid & (b_wsel != '0);
`else
    assign byp = 1'b0;
`endif

    assign push = b_valid & b_ready & (b_wsel != '0) & !byp;
    assign pop  = !a_eff & !empty;

    always_comb begin
        rf_wen  = 1'b0;
        rf_wsel = '0;
        rf_wdat = '0;
        if (a_eff) begin
            rf_wen  = 1'b1;
            rf_wsel = a_wsel;
            rf_wdat = a_wdat;
        end else if (!empty) begin
            rf_wen  = 1'b1;
            rf_wsel = mem_wsel[rd_ptr];
            rf_wdat = mem_wdat[rd_ptr];
        end else if (byp) begin
            rf_wen  = 1'b1;
            rf_wsel = b_wsel;
            rf_wdat = b_wdat;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [AW-1:0] offset;
        hit1   = 1'b0;
        hit2   = 1'b0;
        offset = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr;
            if ({1'b0, offset} < count) begin
                if (mem_wsel[i] == rsel1) hit1 = 1'b1;
                if (mem_wsel[i] == rsel2) hit2 = 1'b1;
            end
        end
        if (rsel1 == '0) hit1 = 1'b0;
        if (rsel2 == '0) hit2 = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_wsel[wr_ptr] <= b_wsel;
            mem_wdat[wr_ptr] <= b_wdat;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);

            if (empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_MAX))
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign stall_req = (starve_cnt == CW'(STARVE_MAX));

endmodule
